// File: rtl/snoop_rr_arbiter.sv
// Round-robin merge of several CCU snoop sources onto a single cache snoop port.
// One transaction (AC, CR, optional CD burst) is outstanding at a time.

package snoop_rr_arbiter_pkg;

    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 64;

    typedef struct packed {
        logic [AddrW-1:0] addr;
        logic [3:0]       snoop;
        logic [2:0]       prot;
    } ac_chan_t;

    typedef struct packed {
        logic [4:0] resp;
    } cr_chan_t;

    typedef struct packed {
        logic [DataW-1:0] data;
        logic             last;
    } cd_chan_t;

    typedef struct packed {
        logic     ac_valid;
        ac_chan_t ac;
        logic     cr_ready;
        logic     cd_ready;
    } snoop_req_t;

    typedef struct packed {
        logic     ac_ready;
        logic     cr_valid;
        cr_chan_t cr;
        logic     cd_valid;
        cd_chan_t cd;
    } snoop_resp_t;

endpackage

module snoop_rr_arbiter #(
    parameter int unsigned NoSlvPorts = 2,
    parameter type ac_chan_t    = snoop_rr_arbiter_pkg::ac_chan_t,
    parameter type cr_chan_t    = snoop_rr_arbiter_pkg::cr_chan_t,
    parameter type cd_chan_t    = snoop_rr_arbiter_pkg::cd_chan_t,
    parameter type snoop_req_t  = snoop_rr_arbiter_pkg::snoop_req_t,
    parameter type snoop_resp_t = snoop_rr_arbiter_pkg::snoop_resp_t
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  snoop_req_t  slv_reqs_i  [NoSlvPorts],
    output snoop_resp_t slv_resps_o [NoSlvPorts],
    output snoop_req_t  mst_req_o,
    input  snoop_resp_t mst_resp_i
);

    localparam int unsigned IdxW = (NoSlvPorts > 1) ? $clog2(NoSlvPorts) : 1;

    typedef enum logic [1:0] {
        IDLE,
        AC,
        CR,
        CD
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   rr_q, rr_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    ac_chan_t          ac_q, ac_d;

    logic              arb_found;
    logic [IdxW-1:0]   arb_idx;
    int unsigned       cand;
    logic [IdxW-1:0]   cand_idx;
    cr_chan_t          cr_fwd;
    cd_chan_t          cd_fwd;

    // State and captured request; reset abandons any in-flight transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rr_q    <= '0;
            idx_q   <= '0;
            ac_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            idx_q   <= idx_d;
            ac_q    <= ac_d;
        end
    end

    // First requester at or after rr_q, scanning with wrap-around.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned i = 0; i < NoSlvPorts; i++) begin
            cand = 32'(rr_q) + i;
            if (cand >= NoSlvPorts) begin
                cand = cand - NoSlvPorts;
            end
            cand_idx = IdxW'(cand);
            if (!arb_found && slv_reqs_i[cand_idx].ac_valid) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    // Next state and channel routing; everything idles to zero while in reset.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        idx_d     = idx_q;
        ac_d      = ac_q;
        mst_req_o = '0;
        for (int unsigned j = 0; j < NoSlvPorts; j++) begin
            slv_resps_o[j] = '0;
        end
        cr_fwd = mst_resp_i.cr;
        cd_fwd = mst_resp_i.cd;

        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    if (arb_found) begin
                        slv_resps_o[arb_idx].ac_ready = 1'b1;
                        ac_d    = slv_reqs_i[arb_idx].ac;
                        idx_d   = arb_idx;
                        rr_d    = (arb_idx == IdxW'(NoSlvPorts - 1)) ? '0 : arb_idx + IdxW'(1);
                        state_d = AC;
                    end
                end
                AC: begin
                    mst_req_o.ac_valid = 1'b1;
                    mst_req_o.ac       = ac_q;
                    if (mst_resp_i.ac_ready) begin
                        state_d = CR;
                    end
                end
                CR: begin
                    slv_resps_o[idx_q].cr_valid = mst_resp_i.cr_valid;
                    slv_resps_o[idx_q].cr       = cr_fwd;
                    mst_req_o.cr_ready          = slv_reqs_i[idx_q].cr_ready;
                    if (mst_resp_i.cr_valid && slv_reqs_i[idx_q].cr_ready) begin
                        state_d = cr_fwd.resp[0] ? CD : IDLE;
                    end
                end
                CD: begin
                    slv_resps_o[idx_q].cd_valid = mst_resp_i.cd_valid;
                    slv_resps_o[idx_q].cd       = cd_fwd;
                    mst_req_o.cd_ready          = slv_reqs_i[idx_q].cd_ready;
                    if (mst_resp_i.cd_valid && slv_reqs_i[idx_q].cd_ready && cd_fwd.last) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snoop_rr_arbiter.sv
// Randomised transaction-level bench for snoop_rr_arbiter with two snoop sources.

module tb_snoop_rr_arbiter;
    import snoop_rr_arbiter_pkg::*;

    localparam int unsigned N = 2;

    logic        clk = 1'b0;
    logic        rst;
    snoop_req_t  slv_reqs  [N];
    snoop_resp_t slv_resps [N];
    snoop_req_t  mst_req;
    snoop_resp_t mst_resp;

    int       checks   = 0;
    int       failures = 0;
    int       ptr      = 0;    // model: next source to be favoured
    ac_chan_t req_ac [N];      // model: payload captured at each source's grant

    always #5 clk = ~clk;

    snoop_rr_arbiter #(.NoSlvPorts(N)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .slv_reqs_i (slv_reqs),
        .slv_resps_o(slv_resps),
        .mst_req_o  (mst_req),
        .mst_resp_i (mst_resp)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    function automatic int exp_winner(input logic [N-1:0] v);
        for (int i = 0; i < int'(N); i++) begin
            int c;
            c = (ptr + i) % int'(N);
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic clear_inputs;
        mst_resp = '0;
        for (int i = 0; i < int'(N); i++) slv_reqs[i] = '0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        ptr = 0;
    endtask

    // Present requests in an IDLE cycle and check which source gets ac_ready.
    task automatic grant(input logic [N-1:0] v, input bit hold, input bit fix,
                         input logic [31:0] addr, output int k);
        snoop_resp_t exp_r;
        for (int i = 0; i < int'(N); i++) begin
            slv_reqs[i].ac_valid = v[i];
            if (v[i]) begin
                slv_reqs[i].ac = ac_chan_t'({$urandom, 4'($urandom), 3'($urandom)});
                if (fix) slv_reqs[i].ac.addr = addr;
            end
        end
        k = exp_winner(v);
        settle();
        checks++;
        if (mst_req !== '0) begin
            failures++;
            $display("FAIL grant_mst_idle got=%h want=0", mst_req);
        end
        for (int i = 0; i < int'(N); i++) begin
            exp_r = '0;
            exp_r.ac_ready = (i == k);
            checks++;
            if (slv_resps[i] !== exp_r) begin
                failures++;
                $display("FAIL grant_slv%0d got=%h want=%h", i, slv_resps[i], exp_r);
            end
        end
        if (k >= 0) begin
            req_ac[k] = slv_reqs[k].ac;
            ptr = (k + 1) % int'(N);
        end
        tick();
        if (!hold) begin
            for (int i = 0; i < int'(N); i++) slv_reqs[i].ac_valid = 1'b0;
        end
    endtask

    // Drive one granted transaction from the AC cycle to completion, cycle by cycle.
    task automatic serve(input int k, input logic [4:0] resp, input int beats, input int stall,
                         input int abort_after, input int pulse_j);
        snoop_resp_t exp_s [N];
        snoop_req_t  exp_m;
        logic [63:0] bd [4];
        int   ph = 0;    // 0 AC, 1 CR, 2 CD, 3 done
        int   stall_left = stall;
        int   crw = 0;
        int   got = 0;
        logic rdy = 1'b0;
        for (int b = 0; b < 4; b++) bd[b] = {$urandom, $urandom};
        for (int cyc = 0; cyc < 60 && ph != 3; cyc++) begin
            mst_resp = '0;
            slv_reqs[k].cr_ready = 1'b0;
            slv_reqs[k].cd_ready = 1'b0;
            if (pulse_j >= 0) slv_reqs[pulse_j].ac_valid = (ph == 1 && crw == 0);
            exp_m = '0;
            for (int j = 0; j < int'(N); j++) exp_s[j] = '0;
            case (ph)
                0: begin
                    mst_resp.ac_ready = (stall_left == 0);
                    exp_m.ac_valid = 1'b1;
                    exp_m.ac       = req_ac[k];
                end
                1: begin
                    mst_resp.cr_valid   = 1'b1;
                    mst_resp.cr.resp    = resp;
                    mst_resp.cd_valid   = 1'b1;
                    mst_resp.cd.data    = bd[0];
                    mst_resp.cd.last    = 1'b1;
                    slv_reqs[k].cr_ready = (crw > 0);
                    slv_reqs[k].cd_ready = 1'b1;
                    exp_s[k].cr_valid   = 1'b1;
                    exp_s[k].cr.resp    = resp;
                    exp_m.cr_ready      = (crw > 0);
                end
                default: begin
                    rdy = 1'(cyc % 2);
                    mst_resp.cd_valid    = 1'b1;
                    mst_resp.cd.data     = bd[got];
                    mst_resp.cd.last     = (got == beats - 1);
                    slv_reqs[k].cd_ready = rdy;
                    exp_s[k].cd_valid    = 1'b1;
                    exp_s[k].cd.data     = bd[got];
                    exp_s[k].cd.last     = (got == beats - 1);
                    exp_m.cd_ready       = rdy;
                end
            endcase
            settle();
            checks++;
            if (mst_req !== exp_m) begin
                failures++;
                $display("FAIL serve_mst ph=%0d got=%h want=%h", ph, mst_req, exp_m);
            end
            for (int j = 0; j < int'(N); j++) begin
                checks++;
                if (slv_resps[j] !== exp_s[j]) begin
                    failures++;
                    $display("FAIL serve_slv%0d ph=%0d got=%h want=%h", j, ph, slv_resps[j], exp_s[j]);
                end
            end
            tick();
            case (ph)
                0: if (stall_left == 0) ph = 1; else stall_left--;
                1: if (crw > 0) ph = resp[0] ? 2 : 3; else crw++;
                default: begin
                    if (rdy) begin
                        got++;
                        if (got == beats) ph = 3;
                        else if (got == abort_after) return;
                    end
                end
            endcase
        end
        checks++;
        if (ph != 3) begin
            failures++;
            $display("FAIL serve_timeout got_phase=%0d want=3", ph);
        end
        mst_resp = '0;
        slv_reqs[k].cr_ready = 1'b0;
        slv_reqs[k].cd_ready = 1'b0;
    endtask

    // All outputs must be zero in the current cycle.
    task automatic check_quiet(input string name);
        checks++;
        if (mst_req !== '0) begin
            failures++;
            $display("FAIL %s_mst got=%h want=0", name, mst_req);
        end
        for (int j = 0; j < int'(N); j++) begin
            checks++;
            if (slv_resps[j] !== '0) begin
                failures++;
                $display("FAIL %s_slv%0d got=%h want=0", name, j, slv_resps[j]);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            slv_reqs[i] = snoop_req_t'({$urandom, $urandom});
            slv_reqs[i].ac_valid = 1'b1;
        end
        mst_resp = snoop_resp_t'({$urandom, $urandom, $urandom});
        tick();
        settle();
        check_quiet("reset_during");
        tick();
        rst = 1'b0;
        clear_inputs();
        ptr = 0;
        settle();
        check_quiet("reset_after");
        tick();
    endtask

    task automatic test_single;
        int k;
        do_reset();
        grant(2'b01, 1'b0, 1'b1, 32'h1000, k);
        serve(k, 5'h00, 1, 0, -1, -1);
        settle();
        check_quiet("single_idle");
        tick();
    endtask

    task automatic test_back_to_back;
        int k;
        do_reset();
        for (int t = 0; t < 4; t++) begin
            grant(2'b11, 1'b1, 1'b0, 32'h0, k);
            serve(k, 5'h00, 1, 0, -1, -1);
        end
        clear_inputs();
    endtask

    task automatic test_cd_burst;
        int k;
        grant(2'b10, 1'b0, 1'b0, 32'h0, k);
        serve(k, 5'h01, 4, 0, -1, -1);
        settle();
        check_quiet("cd_idle");
        tick();
    endtask

    task automatic test_ac_stall;
        int k;
        grant(2'b11, 1'b1, 1'b0, 32'h0, k);
        serve(k, 5'h00, 1, 5, -1, -1);
        clear_inputs();
    endtask

    task automatic test_reset_mid;
        int k;
        grant(2'b01, 1'b0, 1'b0, 32'h0, k);
        serve(k, 5'h01, 4, 0, 2, -1);
        rst = 1'b1;
        settle();
        check_quiet("rstmid_during");
        tick();
        rst = 1'b0;
        clear_inputs();
        ptr = 0;
        settle();
        check_quiet("rstmid_after");
        tick();
        grant(2'b11, 1'b0, 1'b0, 32'h0, k);
        serve(k, 5'h00, 1, 0, -1, -1);
        grant(2'b10, 1'b0, 1'b0, 32'h0, k);
        serve(k, 5'h01, 2, 1, -1, -1);
    endtask

    task automatic test_drop;
        int k;
        grant(2'b01, 1'b0, 1'b0, 32'h0, k);
        serve(k, 5'h00, 1, 1, -1, 1);
        for (int c = 0; c < 3; c++) begin
            settle();
            check_quiet("drop_idle");
            tick();
        end
    endtask

    task automatic test_random;
        int k;
        logic [N-1:0] v;
        for (int it = 0; it < 25; it++) begin
            v = N'($urandom_range(0, 3));
            if (v == '0) begin
                for (int i = 0; i < int'(N); i++) slv_reqs[i].ac_valid = 1'b0;
                settle();
                check_quiet("rand_idle");
                tick();
            end else begin
                grant(v, 1'($urandom_range(0, 1)), 1'b0, 32'h0, k);
                serve(k, 5'($urandom_range(0, 31)), int'($urandom_range(1, 4)),
                      int'($urandom_range(0, 3)), -1, -1);
            end
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_cd_burst();
        test_ac_stall();
        test_reset_mid();
        test_drop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
